// File: rtl/sar_pkg.sv
// sar_pkg: shared state encoding, defaults and sizing helpers for the SAR ADC controller
package sar_pkg;
   typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_SAMPLE_CYC = 4;
   localparam int DEF_SETTLE = 3;
   localparam int DEF_OSR_LOG2 = 0;
   function automatic int result_width(int width, int osr_log2);
      return width + osr_log2;
   endfunction
   function automatic int latency(int width, int sample_cyc, int settle, int osr_log2);
      return (sample_cyc + width * settle + 1) << osr_log2;
   endfunction
endpackage

// File: rtl/sar_adc_ctrl_sync2.sv
// sync2: two-flop synchroniser for an asynchronous single-bit input
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic s1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {q, s1} <= 2'b00;
      else {q, s1} <= {s1, d};
endmodule

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation ADC controller with oversampling, continuous mode
// and a valid/ready result port with sticky overrun detection.
module sar_adc_ctrl
   import sar_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
   parameter int SETTLE     = DEF_SETTLE,
   parameter int OSR_LOG2   = DEF_OSR_LOG2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ena,
   input  logic                      start,
   input  logic                      cont,
   input  logic                      comp_in,
   output logic                      sample_o,
   output logic [WIDTH-1:0]          dac_code,
   output logic                      busy,
   output logic [WIDTH+OSR_LOG2-1:0] result,
   output logic                      result_valid,
   input  logic                      result_ready,
   output logic                      overrun
);
   localparam int RW = result_width(WIDTH, OSR_LOG2);
   localparam int CW = $clog2((SAMPLE_CYC > SETTLE ? SAMPLE_CYC : SETTLE) + 1);
   localparam int IW = $clog2(WIDTH);
   localparam int OW = OSR_LOG2 > 0 ? OSR_LOG2 : 1;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [OW-1:0] osr_cnt;
   logic [RW-1:0] acc;
   logic [WIDTH-1:0] trial;
   logic comp_s, samp_end, bit_end, osr_last, write, accept;
   sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(comp_in), .q(comp_s));
   assign samp_end = state == SAMPLE && cnt == CW'(SAMPLE_CYC - 1);
   assign bit_end  = state == CONVERT && cnt == CW'(SETTLE - 1);
   assign osr_last = osr_cnt == OW'((1 << OSR_LOG2) - 1);
   assign write    = state == DONE && ena && osr_last;
   assign accept   = result_valid && result_ready;
   assign busy     = state != IDLE;
   assign sample_o = state == SAMPLE;
   // Resolve the current bit from the comparator and raise the next lower trial bit.
   assign trial = (comp_s ? dac_code : dac_code & ~(WIDTH'(1) << idx))
                | (idx != '0 ? WIDTH'(1) << (idx - IW'(1)) : '0);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start || cont ? SAMPLE : IDLE;
         SAMPLE:  state_n = samp_end ? CONVERT : SAMPLE;
         CONVERT: state_n = bit_end && idx == '0 ? DONE : CONVERT;
         DONE:    state_n = !osr_last || cont ? SAMPLE : IDLE;
         default: state_n = IDLE;
      endcase
      if (!ena) state_n = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt          <= '0;
         idx          <= '0;
         osr_cnt      <= '0;
         acc          <= '0;
         dac_code     <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         cnt <= (state == SAMPLE || state == CONVERT) && !samp_end && !bit_end && state_n == state
              ? cnt + CW'(1) : '0;
         idx <= samp_end ? IW'(WIDTH - 1) : bit_end ? idx - IW'(1) : idx;
         dac_code <= state_n == IDLE || state_n == SAMPLE ? '0
                   : samp_end ? WIDTH'(1) << (WIDTH - 1)
                   : bit_end ? trial : dac_code;
         acc     <= !ena ? '0 : state == DONE ? (osr_last ? '0 : acc + RW'(dac_code)) : acc;
         osr_cnt <= !ena ? '0 : state == DONE ? (osr_last ? '0 : osr_cnt + OW'(1)) : osr_cnt;
         if (write) result <= acc + RW'(dac_code);
         result_valid <= write ? 1'b1 : accept ? 1'b0 : result_valid;
         overrun      <= write && result_valid && !result_ready ? 1'b1 : accept ? 1'b0 : overrun;
      end
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl: directed bench for sar_adc_ctrl with an ideal zero-delay comparator,
// one default instance and one with 4x oversampling.
module tb_sar_adc_ctrl;
   logic clk = 0, rst_n = 0;
   logic ena = 1, start = 0, cont = 0, ready = 0;
   logic [7:0] vin = 8'h00;
   logic sample_o, busy, valid, overrun;
   logic [7:0] dac, result;
   logic ena1 = 0, start1 = 0, ready1 = 0;
   logic [7:0] vin1 = 8'h40;
   logic sample1, busy1, valid1, overrun1;
   logic [7:0] dac1;
   logic [9:0] result1;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   sar_adc_ctrl u0 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cont(cont),
      .comp_in(dac <= vin), .sample_o(sample_o), .dac_code(dac), .busy(busy),
      .result(result), .result_valid(valid), .result_ready(ready), .overrun(overrun)
   );

   sar_adc_ctrl #(.OSR_LOG2(2)) u1 (
      .clk(clk), .rst_n(rst_n), .ena(ena1), .start(start1), .cont(1'b0),
      .comp_in(dac1 <= vin1), .sample_o(sample1), .dac_code(dac1), .busy(busy1),
      .result(result1), .result_valid(valid1), .result_ready(ready1), .overrun(overrun1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1;
      tick(1);
      start = 0;
   endtask

   task automatic accept();
      ready = 1;
      tick(1);
      ready = 0;
      check("accept_clears_valid", 32'(valid), 32'd0);
   endtask

   initial begin
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_sample", 32'(sample_o), 0);
      check("rst_dac", 32'(dac), 0);
      check("rst_result", 32'(result), 0);
      check("rst_valid", 32'(valid), 0);
      check("rst_overrun", 32'(overrun), 0);
      #13 rst_n = 1;
      tick(1);

      // single conversion of 0xA5, with trial-code trace and latency edge
      vin = 8'hA5;
      pulse_start();
      check("a5_sample", 32'(sample_o), 1);
      check("a5_busy", 32'(busy), 1);
      tick(4);
      check("a5_dac_b7", 32'(dac), 32'h80);
      check("a5_sample_off", 32'(sample_o), 0);
      tick(3);
      check("a5_dac_b6", 32'(dac), 32'hC0);
      tick(3);
      check("a5_dac_b5", 32'(dac), 32'hA0);
      tick(18);
      check("a5_valid_e28", 32'(valid), 0);
      check("a5_busy_e28", 32'(busy), 1);
      tick(1);
      check("a5_valid_e29", 32'(valid), 1);
      check("a5_result", 32'(result), 32'hA5);
      check("a5_busy_e29", 32'(busy), 0);
      check("a5_dac_idle", 32'(dac), 0);
      accept();

      // full-scale boundaries
      vin = 8'h00;
      pulse_start();
      tick(4);
      check("z_dac_b7", 32'(dac), 32'h80);
      tick(3);
      check("z_dac_b6", 32'(dac), 32'h40);
      tick(22);
      check("z_valid", 32'(valid), 1);
      check("z_result", 32'(result), 32'h00);
      accept();
      vin = 8'hFF;
      pulse_start();
      tick(7);
      check("ff_dac_b6", 32'(dac), 32'hC0);
      tick(22);
      check("ff_valid", 32'(valid), 1);
      check("ff_result", 32'(result), 32'hFF);
      accept();

      // 4x oversampling instance
      ena1 = 1;
      start1 = 1;
      tick(1);
      start1 = 0;
      tick(115);
      check("osr_valid_e115", 32'(valid1), 0);
      check("osr_busy_e115", 32'(busy1), 1);
      tick(1);
      check("osr_valid_e116", 32'(valid1), 1);
      check("osr_result", 32'(result1), 32'h100);
      check("osr_busy_e116", 32'(busy1), 0);
      tick(40);
      check("osr_single_result", 32'(busy1), 0);
      check("osr_overrun", 32'(overrun1), 0);

      // continuous mode, unread result overwritten
      vin = 8'hA5;
      cont = 1;
      tick(1);
      tick(29);
      check("cont_valid1", 32'(valid), 1);
      check("cont_result1", 32'(result), 32'hA5);
      check("cont_overrun1", 32'(overrun), 0);
      vin = 8'h3C;
      tick(29);
      check("cont_result2", 32'(result), 32'h3C);
      check("cont_overrun2", 32'(overrun), 1);
      check("cont_valid2", 32'(valid), 1);
      cont = 0;
      ready = 1;
      tick(1);
      ready = 0;
      check("ovr_accept_valid", 32'(valid), 0);
      check("ovr_accept_overrun", 32'(overrun), 0);
      tick(28);
      check("cont_drop_valid", 32'(valid), 1);
      check("cont_drop_result", 32'(result), 32'h3C);
      check("cont_drop_idle", 32'(busy), 0);
      accept();

      // asynchronous reset mid-conversion
      vin = 8'hA5;
      pulse_start();
      tick(12);
      check("arst_pre_dac", 32'(dac), 32'hA0);
      rst_n = 0;
      #1;
      check("arst_busy", 32'(busy), 0);
      check("arst_dac", 32'(dac), 0);
      check("arst_result", 32'(result), 0);
      check("arst_valid", 32'(valid), 0);
      check("arst_sample", 32'(sample_o), 0);
      #3 rst_n = 1;
      tick(1);
      pulse_start();
      tick(29);
      check("arst_again_valid", 32'(valid), 1);
      check("arst_again_result", 32'(result), 32'hA5);

      // ena low mid-conversion keeps old result; start while busy is dropped
      vin = 8'h11;
      pulse_start();
      tick(5);
      pulse_start();
      tick(6);
      ena = 0;
      tick(1);
      check("ena_busy", 32'(busy), 0);
      check("ena_sample", 32'(sample_o), 0);
      check("ena_dac", 32'(dac), 0);
      check("ena_result_kept", 32'(result), 32'hA5);
      check("ena_valid_kept", 32'(valid), 1);
      ena = 1;
      tick(40);
      check("ena_no_queued_start", 32'(busy), 0);
      check("ena_result_same", 32'(result), 32'hA5);
      check("ena_overrun", 32'(overrun), 0);
      accept();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
